// File: rtl/fpcvt_seq.sv
// ============================================================================
// Module      : fpcvt_seq
// Description : Sequential two's-complement to floating-point converter.
//               Normalises one bit per cycle, then rounds and saturates.
//               Optional `inexact` output is enabled by FPCVT_INEXACT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpcvt_seq #(
   parameter int W  = 12,
   parameter int EW = 3,
   parameter int MW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  d,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          s,
   output logic [EW-1:0] e,
   output logic [MW-1:0] f
`ifdef FPCVT_INEXACT_EN
   ,
   output logic          inexact
`endif
);

   typedef enum logic [1:0] {IDLE, NORM, RND, OUT} state_t;

   localparam logic [EW-1:0] EXP_INIT = EW'(W - 1 - MW);
   localparam logic [W-1:0]  MOST_NEG = {1'b1, {(W-1){1'b0}}};
   localparam logic [MW-1:0] F_HALF   = {1'b1, {(MW-1){1'b0}}};

   state_t        r_state;
   state_t        w_state_next;
   logic [W-2:0]  r_mag;
   logic [EW-1:0] r_exp;
   logic          r_sign;

   logic          w_accept;
   logic          w_most_neg;
   logic [W-1:0]  w_d_abs;
   logic          w_norm_done;
   logic [MW-1:0] w_f0;
   logic          w_rbit;
   logic [MW-1:0] w_f_rnd;
   logic [EW-1:0] w_e_rnd;

   assign in_ready    = (r_state == IDLE) && !rst;
   assign w_accept    = in_valid && in_ready;
   assign w_most_neg  = (d == MOST_NEG);
   assign w_d_abs     = d[W-1] ? -d : d;
   assign w_norm_done = r_mag[W-2] || (r_exp == '0);

   // Rounding is suppressed in the denormal region (exp == 0).
   assign w_f0   = r_mag[W-2 -: MW];
   assign w_rbit = (r_exp != '0) && r_mag[W-2-MW];

   always_comb begin
      w_f_rnd = w_f0;
      w_e_rnd = r_exp;
      if (w_rbit) begin
         if (!(&w_f0)) begin
            w_f_rnd = w_f0 + MW'(1);
         end else if (r_exp == EXP_INIT) begin
            w_f_rnd = '1;
         end else begin
            w_f_rnd = F_HALF;
            w_e_rnd = r_exp + EW'(1);
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept) w_state_next = w_most_neg ? OUT : NORM;
         NORM: if (w_norm_done) w_state_next = RND;
         RND:  w_state_next = OUT;
         OUT:  if (out_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mag     <= '0;
         r_exp     <= '0;
         r_sign    <= 1'b0;
         out_valid <= 1'b0;
         s         <= 1'b0;
         e         <= '0;
         f         <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_sign <= d[W-1];
                  if (w_most_neg) begin
                     s         <= 1'b1;
                     e         <= '1;
                     f         <= '1;
                     out_valid <= 1'b1;
                  end else begin
                     r_mag <= w_d_abs[W-2:0];
                     r_exp <= EXP_INIT;
                  end
               end
            end
            NORM: begin
               if (!w_norm_done) begin
                  r_mag <= {r_mag[W-3:0], 1'b0};
                  r_exp <= r_exp - EW'(1);
               end
            end
            RND: begin
               s         <= r_sign;
               e         <= w_e_rnd;
               f         <= w_f_rnd;
               out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef FPCVT_INEXACT_EN
   logic w_inexact_rnd;

   // Lost low bits, or a round-up that saturation swallowed.
   assign w_inexact_rnd = (|r_mag[W-2-MW:0]) ||
                          (w_rbit && (&w_f0) && (r_exp == EXP_INIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         inexact <= 1'b0;
      end else if (r_state == IDLE && w_accept) begin
         inexact <= w_most_neg;
      end else if (r_state == RND) begin
         inexact <= w_inexact_rnd;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fpcvt_seq.sv
// ============================================================================
// Module      : tb_fpcvt_seq
// Description : Directed scoreboard bench for fpcvt_seq (W=12, EW=3, MW=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpcvt_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] d;
   logic        out_valid;
   logic        out_ready;
   logic        s;
   logic [2:0]  e;
   logic [3:0]  f;
`ifdef FPCVT_INEXACT_EN
   logic        inexact;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // lat = clock edges after the accept edge until out_valid is seen high
   typedef struct packed {
      logic       s;
      logic [2:0] e;
      logic [3:0] f;
      logic       inx;
      logic [7:0] lat;
   } exp_t;

   exp_t sb[$];

   fpcvt_seq #(.W(12), .EW(3), .MW(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d         (d),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .e         (e),
      .f         (f)
`ifdef FPCVT_INEXACT_EN
      ,
      .inexact   (inexact)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic convert(input logic [11:0] din, input logic es, input logic [2:0] ee,
                          input logic [3:0] ef, input logic einx, input int elat,
                          input int hold);
      exp_t x;
      int   cnt;
      logic [7:0] held;
      @(negedge clk);
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      sb.push_back({es, ee, ef, einx, 8'(elat)});
      d        = din;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      x = sb.pop_front();
      chk($sformatf("out_valid_%03h", din), 32'(out_valid), 32'd1);
      chk($sformatf("latency_%03h", din), 32'(cnt), 32'(x.lat));
      chk($sformatf("s_%03h", din), 32'(s), 32'(x.s));
      chk($sformatf("e_%03h", din), 32'(e), 32'(x.e));
      chk($sformatf("f_%03h", din), 32'(f), 32'(x.f));
`ifdef FPCVT_INEXACT_EN
      chk($sformatf("inexact_%03h", din), 32'(inexact), 32'(x.inx));
`endif
      held = {s, e, f};
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         d        = 12'h7FF;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         chk("hold_out_valid", 32'(out_valid), 32'd1);
         chk("hold_stable_sef", 32'({s, e, f}), 32'(held));
         chk("hold_in_ready", 32'(in_ready), 32'd0);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("taken_out_valid", 32'(out_valid), 32'd0);
      chk("in_ready_after_take", 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic seen;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      d         = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_sef", 32'({s, e, f}), 32'd0);
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", 32'(in_ready), 32'd1);

      //        d        s     e       f        inx   lat hold
      convert(12'h000, 1'b0, 3'b000, 4'b0000, 1'b0, 9, 0);
      convert(12'h800, 1'b1, 3'b111, 4'b1111, 1'b1, 0, 0);
      convert(12'h7FF, 1'b0, 3'b111, 4'b1111, 1'b1, 2, 0);
      convert(12'h0F8, 1'b0, 3'b101, 4'b1000, 1'b1, 5, 0);
      convert(12'hFF0, 1'b1, 3'b001, 4'b1000, 1'b0, 8, 0);
      convert(12'h00D, 1'b0, 3'b000, 4'b1101, 1'b0, 9, 0);
      convert(12'h123, 1'b0, 3'b101, 4'b1001, 1'b1, 4, 3);

      // Abort a conversion with reset in the second NORM cycle.
      @(negedge clk);
      d        = 12'h001;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort_out_valid", 32'(out_valid), 32'd0);
      chk("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_in_ready_after", 32'(in_ready), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      chk("abort_no_output", 32'(seen), 32'd0);

      convert(12'h010, 1'b0, 3'b001, 4'b1000, 1'b0, 8, 0);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
